prog_mem_loader: RTL

- Parametrised, synchronous successor to the fixed asynchronous program ROM.
- Holds the CPU instruction image in an on-chip array and gives the CPU a registered fetch port.
- Adds a byte-serial load port with a valid/ready handshake, so programs can be written at run time rather than hard-coded.
- Sits between the CPU fetch stage and an external loader (UART/debug bridge).

---
 rtl/prog_mem_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: on-chip instruction memory with a registered CPU fetch port
// and a byte-serial, run-time load port (valid/ready handshake).
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   fetch_addr     - CPU instruction address
//   fetch_data     - registered mem[fetch_addr] (1-cycle latency), 0 while busy
//   fetch_stall    - equals busy; the CPU holds fetch while a load runs
//   load_start     - one-cycle pulse; samples load_base / load_count in IDLE
//   load_base      - first word address of the load
//   load_count     - number of words to load (0 allowed)
//   load_abort     - cancels the load in progress; written words stay written
//   byte_data      - load byte, little-endian within each word
//   byte_valid     - byte_data valid
//   byte_ready     - a byte is accepted this cycle when byte_valid is also high
//   busy           - a load is in progress
//   load_done      - one-cycle pulse when a load completes normally
//   load_err       - checksum mismatch flag (constant 0 without the checksum)
//
// Build option: define PROG_MEM_LOADER_CHECKSUM_EN to require one trailing
// XOR checksum byte per load and report a mismatch on load_err.
module prog_mem_loader #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned INSTR_W        = 35,
    parameter int unsigned BYTES_PER_WORD = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] fetch_data,
    output logic               fetch_stall,
    input  logic               load_start,
    input  logic [ADDR_W-1:0]  load_base,
    input  logic [ADDR_W:0]    load_count,
    input  logic               load_abort,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               busy,
    output logic               load_done,
    output logic               load_err
);

    localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [IDX_W-1:0]  LastLane = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0]  IdxOne   = IDX_W'(1);
    localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   OneWord  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [ADDR_W:0]    remaining_q;
    logic [IDX_W-1:0]   idx_q;
    logic [INSTR_W-1:0] word_q;
    logic               mem_we;

    // Not reset: the image survives a CPU reset.
    logic [INSTR_W-1:0] mem [Depth];

    assign busy        = (state_q != StIdle);
    assign fetch_stall = busy;
    // Abort wins over the write of a just-completed word.
    assign mem_we      = (state_q == StWrite) && !load_abort;

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    assign byte_ready = (state_q == StCollect) || (state_q == StCsum);
`else
    assign byte_ready = (state_q == StCollect);
    assign load_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= word_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_data <= '0;
        end else begin
            fetch_data <= busy ? '0 : mem[fetch_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            load_done   <= 1'b0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
            load_err    <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            if (busy && load_abort) begin
                // Partial word is dropped; words already written are kept.
                state_q <= StIdle;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (load_start) begin
                            ptr_q       <= load_base;
                            remaining_q <= load_count;
                            idx_q       <= '0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                            load_err    <= 1'b0;
                            csum_q      <= '0;
                            state_q     <= (load_count != '0) ? StCollect : StCsum;
`else
                            if (load_count != '0) begin
                                state_q <= StCollect;
                            end else begin
                                state_q   <= StDone;
                                load_done <= 1'b1;
                            end
`endif
                        end
                    end
                    StCollect: begin
                        if (byte_valid) begin
                            // Lane idx covers bits 8*idx+7:8*idx; bits past INSTR_W drop.
                            for (int b = 0; b < int'(INSTR_W); b++) begin
                                if (IDX_W'(b / 8) == idx_q) begin
                                    word_q[b] <= byte_data[3'(b % 8)];
                                end
                            end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                            csum_q <= csum_q ^ byte_data;
`endif
                            if (idx_q == LastLane) begin
                                state_q <= StWrite;
                            end else begin
                                idx_q <= idx_q + IdxOne;
                            end
                        end
                    end
                    StWrite: begin
                        ptr_q       <= ptr_q + PtrOne;
                        remaining_q <= remaining_q - OneWord;
                        idx_q       <= '0;
                        if (remaining_q == OneWord) begin
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                            state_q <= StCsum;
`else
                            state_q   <= StDone;
                            load_done <= 1'b1;
`endif
                        end else begin
                            state_q <= StCollect;
                        end
                    end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                    StCsum: begin
                        if (byte_valid) begin
                            load_err  <= ((csum_q ^ byte_data) != 8'h00);
                            state_q   <= StDone;
                            load_done <= 1'b1;
                        end
                    end
`endif
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
